// File: rtl/demux_1_8_tdm.sv
// demux_1_8_tdm: receive side of an 8:1 TDM lane; hunts for frame_start, then spreads samples over o0..o7.
// Optional macro DEMUX_DBUF_EN: capture into an 8-entry buffer and present whole frames at once.
module demux_1_8_tdm #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in1,
   input  logic         frame_start,
   input  logic         en,
   output logic         S2,
   output logic         S1,
   output logic         S0,
   output logic [W-1:0] o0,
   output logic [W-1:0] o1,
   output logic [W-1:0] o2,
   output logic [W-1:0] o3,
   output logic [W-1:0] o4,
   output logic [W-1:0] o5,
   output logic [W-1:0] o6,
   output logic [W-1:0] o7,
   output logic         frame_valid,
   output logic         sync_err,
   output logic         locked
);

   typedef enum logic {
      HUNT  = 1'b0,
      TRACK = 1'b1
   } state_t;

   state_t       state_q;
   logic [2:0]   slot_q;
   logic         frame_valid_q;
   logic         sync_err_q;
   logic         locked_q;
   logic [W-1:0] lane_q [8];
   logic [W-1:0] lane_d [8];

   logic         wr_en_s;
   logic [2:0]   wr_slot_s;
   logic         mis_s;
   logic         done_s;

   // Accept decode: which slot (if any) the current sample lands in.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_slot_s = slot_q;
      mis_s     = 1'b0;
      done_s    = 1'b0;
      if (en) begin
         case (state_q)
            HUNT: begin
               wr_en_s   = frame_start;
               wr_slot_s = 3'd0;
            end
            TRACK: begin
               wr_en_s = 1'b1;
               if (frame_start) begin
                  wr_slot_s = 3'd0;
                  mis_s     = (slot_q != 3'd0);
               end else begin
                  wr_slot_s = slot_q;
               end
            end
            default: begin
               wr_en_s   = 1'b0;
               wr_slot_s = 3'd0;
            end
         endcase
         // A marker forces slot 0, so a slot-7 write can never coincide with a resync.
         done_s = wr_en_s && (wr_slot_s == 3'd7);
      end else begin
         wr_en_s = 1'b0;
         done_s  = 1'b0;
      end
   end

   // Lock/slot state machine with registered strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= HUNT;
         slot_q        <= 3'd0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
         if (wr_en_s) begin
            state_q       <= TRACK;
            locked_q      <= 1'b1;
            slot_q        <= wr_slot_s + 3'd1;
            sync_err_q    <= mis_s;
            frame_valid_q <= done_s;
         end
      end
   end

`ifdef DEMUX_DBUF_EN
   logic [W-1:0] cap_q [8];
   logic [W-1:0] cap_d [8];

   // Capture buffer fills slot by slot; lanes copy it (including the slot-7 sample) on completion.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         cap_d[k]  = (wr_en_s && (wr_slot_s == 3'(k))) ? in1 : cap_q[k];
         lane_d[k] = done_s ? cap_d[k] : lane_q[k];
      end
   end

   // Capture buffer storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 8; k++) begin
            cap_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 8; k++) begin
            cap_q[k] <= cap_d[k];
         end
      end
   end
`else
   // Lanes update directly as their slot is written.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         lane_d[k] = (wr_en_s && (wr_slot_s == 3'(k))) ? in1 : lane_q[k];
      end
   end
`endif

   // Lane output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 8; k++) begin
            lane_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 8; k++) begin
            lane_q[k] <= lane_d[k];
         end
      end
   end

   assign S2          = slot_q[2];
   assign S1          = slot_q[1];
   assign S0          = slot_q[0];
   assign o0          = lane_q[0];
   assign o1          = lane_q[1];
   assign o2          = lane_q[2];
   assign o3          = lane_q[3];
   assign o4          = lane_q[4];
   assign o5          = lane_q[5];
   assign o6          = lane_q[6];
   assign o7          = lane_q[7];
   assign frame_valid = frame_valid_q;
   assign sync_err    = sync_err_q;
   assign locked      = locked_q;

endmodule

// File: tb/tb_demux_1_8_tdm.sv
// Directed bench for demux_1_8_tdm (W = 1); expectations adapt to DEMUX_DBUF_EN.
module tb_demux_1_8_tdm;

   logic       clk;
   logic       rst_n;
   logic [0:0] in1;
   logic       frame_start;
   logic       en;
   logic       S2, S1, S0;
   logic [0:0] o0, o1, o2, o3, o4, o5, o6, o7;
   logic       frame_valid;
   logic       sync_err;
   logic       locked;

   int errors = 0;
   int checks = 0;
   logic dbuf;
   logic [7:0] lanes_s;
   logic [7:0] f1;

   demux_1_8_tdm #(.W(1)) dut (
      .clk(clk), .rst_n(rst_n), .in1(in1), .frame_start(frame_start), .en(en),
      .S2(S2), .S1(S1), .S0(S0),
      .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
      .frame_valid(frame_valid), .sync_err(sync_err), .locked(locked)
   );

   assign lanes_s = {o7, o6, o5, o4, o3, o2, o1, o0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_all(input string tag, input logic [7:0] s, input logic fv,
                             input logic se, input logic lk, input logic [7:0] lanes);
      chk({tag, "_slot"}, {5'd0, S2, S1, S0}, s);
      chk({tag, "_fv"}, {7'd0, frame_valid}, {7'd0, fv});
      chk({tag, "_se"}, {7'd0, sync_err}, {7'd0, se});
      chk({tag, "_lock"}, {7'd0, locked}, {7'd0, lk});
      chk({tag, "_lanes"}, lanes_s, lanes);
   endtask

   task automatic step(input logic fs, input logic e, input logic d);
      frame_start = fs;
      en          = e;
      in1         = d;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      en          = 1'b0;
      in1         = 1'b0;
   endtask

   initial begin
`ifdef DEMUX_DBUF_EN
      dbuf = 1'b1;
`else
      dbuf = 1'b0;
`endif
      rst_n = 1'b0; in1 = 1'b0; frame_start = 1'b0; en = 1'b0;
      @(posedge clk);
      #1;
      expect_all("reset", 8'd0, 1'b0, 1'b0, 1'b0, 8'h00);
      rst_n = 1'b1;

      // HUNT: samples without a marker are ignored.
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, i[0]);
         expect_all("hunt", 8'd0, 1'b0, 1'b0, 1'b0, 8'h00);
      end

      // Basic frame 1,0,1,1,0,0,1,0.
      f1 = 8'h4D;
      for (int i = 0; i < 8; i++) begin
         step(i == 0, 1'b1, f1[i]);
         expect_all("basic", 8'((i + 1) % 8), i == 7, 1'b0, 1'b1,
                    (i == 3) ? (dbuf ? 8'h00 : 8'h0D) : ((i == 7) ? 8'h4D : lanes_s));
      end

      // Back-to-back frame of all ones.
      for (int i = 0; i < 8; i++) begin
         step(i == 0, 1'b1, 1'b1);
         expect_all("b2b", 8'((i + 1) % 8), i == 7, 1'b0, 1'b1,
                    (i == 7) ? 8'hFF : lanes_s);
      end

      // Misaligned marker at slot 3.
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      expect_all("pre_mis", 8'd3, 1'b0, 1'b0, 1'b1, dbuf ? 8'hFF : 8'hF8);
      step(1'b1, 1'b1, 1'b1);
      expect_all("mis", 8'd1, 1'b0, 1'b1, 1'b1, dbuf ? 8'hFF : 8'hF9);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b1, 1'b0);
         expect_all("resync", 8'((i + 2) % 8), i == 6, 1'b0, 1'b1,
                    (i == 6) ? 8'h01 : lanes_s);
      end

      // Stall for 5 cycles at slot 4; markers while en=0 are ignored.
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      expect_all("pre_stall", 8'd4, 1'b0, 1'b0, 1'b1, dbuf ? 8'h01 : 8'h0F);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b1);
         expect_all("stall", 8'd4, 1'b0, 1'b0, 1'b1, dbuf ? 8'h01 : 8'h0F);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b0);
         expect_all("post_stall", 8'((i + 5) % 8), i == 3, 1'b0, 1'b1,
                    (i == 3) ? 8'h0F : lanes_s);
      end

      // Asynchronous reset mid-frame.
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      expect_all("pre_rst", 8'd2, 1'b0, 1'b0, 1'b1, 8'h0F);
      #2;
      rst_n = 1'b0;
      #1;
      expect_all("async_rst", 8'd0, 1'b0, 1'b0, 1'b0, 8'h00);
      #1;
      rst_n = 1'b1;
      step(1'b0, 1'b1, 1'b1);
      expect_all("rst_hunt", 8'd0, 1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 1'b1);
      expect_all("relock", 8'd1, 1'b0, 1'b0, 1'b1, dbuf ? 8'h00 : 8'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/demux_1_8_tdm.md
# demux_1_8_tdm

Time-division 1-to-8 demultiplexer: receiving end of the 8:1 multiplexed lane driven by the `MUX_8_1` tree. It accepts one serial sample per clock plus a frame-start marker, steps an internal 3-bit slot counter, and deposits each sample into lane register `o<slot>`. Complete frames are flagged with a one-cycle `frame_valid` strobe, and marker misalignment is reported on `sync_err`.

## Interface
- `W`, default 1: width of each lane sample. `in1` and each `o0`..`o7` are `W` bits wide.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `in1`, input, W: serial sample for the current slot.
- `frame_start`, input, 1: marks `in1` as slot 0 of a new frame.
- `en`, input, 1: sample qualifier. When low, the bench or design holds all state.
- `S2`, `S1`, `S0`, output, 1 each: current slot index (MSB..LSB), registered. Mirrors the transmitter's select lines.
- `o0`..`o7`, output, W each: lane outputs. Lane `k` receives the sample from slot `k`.
- `frame_valid`, output, 1: one-cycle pulse when a full frame has landed.
- `sync_err`, output, 1: one-cycle pulse on a misaligned `frame_start`.
- `locked`, output, 1: high once a `frame_start` has been accepted.

## Operation
- Reset values: slot = 0 (`S2..S0` = 000), `o0`..`o7` = 0, `frame_valid` = 0, `sync_err` = 0, `locked` = 0. Internal capture buffer is also cleared to 0.
- State machine has two states.
  - HUNT: entered at reset. Samples are ignored while `frame_start` = 0.
  - HUNT exit: `en` = 1 with `frame_start` = 1 captures `in1` into slot 0, sets slot = 1, and moves to TRACK with `locked` = 1.
  - TRACK, normal step: each `en` = 1 cycle writes `in1` into lane[slot], then slot increments modulo 8 (7 wraps to 0).
- Frame completion: writing slot 7 pulses `frame_valid` on the following cycle.
- Expected markers: `frame_start` = 1 while TRACK slot = 0 is normal and causes no error.
- Unexpected markers: `frame_start` = 1 while TRACK slot != 0 is handled as follows.
  - `sync_err` pulses for one cycle.
  - The partial frame is discarded, so no `frame_valid` is produced for it.
  - `in1` is captured as slot 0 and slot is set to 1. The block resynchronises and stays in TRACK.
- Idle: `en` = 0 holds slot, lanes, and state. `frame_start` is ignored whenever `en` = 0.
- Asynchronous reset mid-frame: all state is cleared immediately. The next frame requires a new `frame_start`.

## Timing
- Sample-to-lane latency is 1 cycle: the edge after `in1` is sampled updates the lane (without `DEMUX_DBUF_EN`) or the buffer (with it).
- `S2..S0` show the slot that the next accepted sample will occupy.
- `frame_valid` asserts one cycle after the slot-7 write edge.
- `sync_err` asserts on the cycle after the offending edge.
- `frame_valid` and `sync_err` never assert together.
- Throughput is one sample per clock, with no bubbles required at frame boundaries.

## Configuration
- Macro: `DEMUX_DBUF_EN`.
- Defined: samples go to an internal 8-entry buffer. `o0`..`o7` load from the buffer all at once on the same edge that raises `frame_valid`, so the outputs are always a coherent frame. A discarded partial frame never reaches the outputs.
- Undefined: lane `k` updates directly when slot `k` is written, so the outputs change progressively across the frame. On a sync error, already-written lanes keep their partial-frame values.

## Test plan
- Reset: drive `rst_n` = 0 mid-stream, asynchronously. All outputs must read 0 and `locked` = 0 before the next clock edge.
- Basic frame: `W` = 1, `frame_start` at cycle 0, `in1` = 1,0,1,1,0,0,1,0 over 8 cycles.
  - Required: `o0..o7` = 1,0,1,1,0,0,1,0.
  - Required: `frame_valid` high on cycle 8 only.
  - Required: `S2..S0` sequence 001..111,000.
- Back-to-back frames: second frame `in1` = all 1s with `frame_start` at cycle 8. Required: `sync_err` = 0, second `frame_valid` at cycle 16, all lanes = 1.
- Misaligned marker: `frame_start` at slot 3. Required: `sync_err` pulses, slot becomes 1, and no `frame_valid` for that frame.
  - With `DEMUX_DBUF_EN`: `o*` keep the previous frame's values.
- Stall: `en` = 0 for 5 cycles at slot 4. Required: `S2..S0` = 100 held, no lane changes, and the frame completes 5 cycles late.
- HUNT: 10 samples with no `frame_start`. Required: `locked` = 0, `o*` = 0, no strobes.
